// File: rtl/ubbka_stream_accumulator.sv
// Frame accumulator: sums BEAT_COUNT streamed 19-bit operands through one
// Brent-Kung adder and hands the frame sum plus a sticky carry flag downstream.

module UBBKA_18_0_18_0 (
  input  logic [18:0] X,
  input  logic [18:0] Y,
  output logic [19:0] S
);

  logic [18:0] g;
  logic [18:0] p;
  logic [18:0] hp;

  always_comb begin
    // NOTE: every variable written here gets a value first, so no latch is inferred.
    hp = X ^ Y;
    g  = X & Y;
    p  = hp;
    // Up-sweep: build power-of-two group generate/propagate spans.
    for (int d = 1; d < 19; d = d * 2) begin
      for (int i = 0; i < 19; i++) begin
        if ((i >= d) && (((i + 1) % (2 * d)) == 0)) begin
          g[i] = g[i] | (p[i] & g[(i >= d) ? i - d : i]);
          p[i] = p[i] & p[(i >= d) ? i - d : i];
        end
      end
    end
    // Down-sweep: fill the remaining prefixes from the completed spans.
    for (int d = 8; d >= 1; d = d / 2) begin
      for (int i = 0; i < 19; i++) begin
        if ((i > d) && (((i + 1) % (2 * d)) == d)) begin
          g[i] = g[i] | (p[i] & g[(i >= d) ? i - d : i]);
          p[i] = p[i] & p[(i >= d) ? i - d : i];
        end
      end
    end
    S = {g[18], hp ^ {g[17:0], 1'b0}};
  end

endmodule

module ubbka_stream_accumulator #(
  parameter int unsigned BEAT_COUNT = 4,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [18:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [18:0] OUT_SUM,
  output logic        OUT_OVF
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_ACC,
    ST_HOLD
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BEAT_COUNT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [18:0] acc;
  logic [18:0] acc_nxt;
  logic        ovf;
  logic        ovf_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [19:0] add_s;

  UBBKA_18_0_18_0 u_add (
    .X (acc),
    .Y (IN_DATA),
    .S (add_s)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RST: state_nxt = ST_ACC;
      ST_ACC: begin
        if (IN_VALID) begin
          ovf_nxt = ovf | add_s[19];
          acc_nxt = (SATURATE && add_s[19]) ? 19'h7FFFF : add_s[18:0];
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = 8'd0;
            state_nxt = ST_HOLD;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          acc_nxt   = 19'd0;
          ovf_nxt   = 1'b0;
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

  // Handshake outputs are flops loaded from the next state, so neither
  // depends combinationally on IN_VALID or OUT_READY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_RST;
      acc       <= 19'd0;
      ovf       <= 1'b0;
      cnt       <= 8'd0;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state     <= state_nxt;
      acc       <= acc_nxt;
      ovf       <= ovf_nxt;
      cnt       <= cnt_nxt;
      IN_READY  <= (state_nxt == ST_ACC);
      OUT_VALID <= (state_nxt == ST_HOLD);
    end
  end

  assign OUT_SUM = acc;
  assign OUT_OVF = ovf;

endmodule

// File: tb/tb_ubbka_stream_accumulator.sv
// Four accumulator configurations share one stimulus stream; each is tracked
// cycle by cycle by a frame-level arithmetic model, plus directed frame checks.

module tb_ubbka_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [18:0] in_data;
  logic        out_ready;

  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic [18:0] out_sum_w   [4];
  logic        out_ovf_w   [4];
  int          frames_w    [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instances: 0 = (4, wrap), 1 = (4, saturate), 2 = (1, wrap), 3 = (255, saturate)
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned BC  = (g == 2) ? 1 : ((g == 3) ? 255 : 4);
    localparam bit          SAT = (g == 1) || (g == 3);

    ubbka_stream_accumulator #(
      .BEAT_COUNT (BC),
      .SATURATE   (SAT)
    ) u_dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready_w[g]),
      .IN_DATA   (in_data),
      .OUT_VALID (out_valid_w[g]),
      .OUT_READY (out_ready),
      .OUT_SUM   (out_sum_w[g]),
      .OUT_OVF   (out_ovf_w[g])
    );

    // Model: live = out of reset, full = frame complete and waiting.
    initial begin
      bit          live;
      bit          full;
      bit          movf;
      int unsigned macc;
      int unsigned total;
      int unsigned beats;
      live = 1'b0; full = 1'b0; movf = 1'b0; macc = 0; beats = 0;
      frames_w[g] = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          live = 1'b0; full = 1'b0; movf = 1'b0; macc = 0; beats = 0;
        end
        check($sformatf("m%0d.in_ready", g), 20'(in_ready_w[g]), 20'(live && !full));
        check($sformatf("m%0d.out_valid", g), 20'(out_valid_w[g]), 20'(full));
        check($sformatf("m%0d.out_sum", g), 20'(out_sum_w[g]), 20'(macc));
        check($sformatf("m%0d.out_ovf", g), 20'(out_ovf_w[g]), 20'(movf));
        if (rst_n) begin
          if (!live) begin
            live = 1'b1;
          end else if (full) begin
            if (out_ready) begin
              full = 1'b0; movf = 1'b0; macc = 0;
              frames_w[g]++;
            end
          end else if (in_valid) begin
            total = macc + 32'(in_data);
            if (total > 32'h7FFFF) begin
              movf = 1'b1;
              macc = SAT ? 32'h7FFFF : total - 32'h80000;
            end else begin
              macc = total;
            end
            beats++;
            if (beats == BC) begin
              beats = 0;
              full  = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [18:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back beats into instances 0 and 1, check the frame, release it.
  task automatic frame4(input logic [18:0] a, input logic [18:0] b,
                        input logic [18:0] c, input logic [18:0] d,
                        input logic [18:0] s0, input logic o0,
                        input logic [18:0] s1, input logic o1);
    send(a); send(b); send(c); send(d);
    in_valid = 1'b0;
    check("f.valid0", 20'(out_valid_w[0]), 20'd1);
    check("f.ready0", 20'(in_ready_w[0]), 20'd0);
    check("f.sum0", 20'(out_sum_w[0]), 20'(s0));
    check("f.ovf0", 20'(out_ovf_w[0]), 20'(o0));
    check("f.sum1", 20'(out_sum_w[1]), 20'(s1));
    check("f.ovf1", 20'(out_ovf_w[1]), 20'(o1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("f.valid0_drop", 20'(out_valid_w[0]), 20'd0);
    check("f.ready0_back", 20'(in_ready_w[0]), 20'd1);
    check("f.sum0_clear", 20'(out_sum_w[0]), 20'd0);
  endtask

  initial begin
    logic [18:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 19'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    check("rst.in_ready", 20'(in_ready_w[0]), 20'd0);
    check("rst.out_valid", 20'(out_valid_w[0]), 20'd0);
    check("rst.out_sum", 20'(out_sum_w[0]), 20'd0);
    check("rst.out_ovf", 20'(out_ovf_w[0]), 20'd0);
    @(posedge clk);
    #1;
    check("rst.ready_rise", 20'(in_ready_w[0]), 20'd1);

    frame4(19'd1, 19'd2, 19'd3, 19'd4, 19'd10, 1'b0, 19'd10, 1'b0);
    frame4(19'h7FFFF, 19'h00001, 19'h00005, 19'd0, 19'h00005, 1'b1, 19'h7FFFF, 1'b1);
    frame4(19'd0, 19'd0, 19'd0, 19'd7, 19'd7, 1'b0, 19'd7, 1'b0);
    frame4(19'h40000, 19'h40000, 19'h00003, 19'd0, 19'h00003, 1'b1, 19'h7FFFF, 1'b1);

    // Back-pressure: frame held for six cycles while a beat waits at the input.
    out_ready = 1'b0;
    send(19'd1); send(19'd1); send(19'd1); send(19'd1);
    in_valid = 1'b1;
    in_data  = 19'd9;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("bp.in_ready", 20'(in_ready_w[0]), 20'd0);
      check("bp.out_sum", 20'(out_sum_w[0]), 20'd4);
      check("bp.out_valid", 20'(out_valid_w[0]), 20'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(19'd9); send(19'd0); send(19'd0); send(19'd0);
    in_valid = 1'b0;
    check("bp.next_sum", 20'(out_sum_w[0]), 20'd9);
    check("bp.next_valid", 20'(out_valid_w[0]), 20'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Bubbles, then an asynchronous reset in the middle of the frame.
    send(19'd5);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(19'd6);
    in_valid = 1'b0;
    check("bub.partial", 20'(out_sum_w[0]), 20'd11);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.in_ready", 20'(in_ready_w[0]), 20'd0);
    check("mrst.out_valid", 20'(out_valid_w[0]), 20'd0);
    check("mrst.out_sum", 20'(out_sum_w[0]), 20'd0);
    check("mrst.out_ovf", 20'(out_ovf_w[0]), 20'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst.ready_back", 20'(in_ready_w[0]), 20'd1);
    frame4(19'd2, 19'd2, 19'd2, 19'd2, 19'd8, 1'b0, 19'd8, 1'b0);

    // Random stream: every instance is compared against its model each cycle.
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 4))
        0:       d = 19'd0;
        1:       d = 19'h7FFFF;
        2:       d = 19'($urandom_range(0, 15));
        default: d = 19'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);

    check("frames.m0", 20'(frames_w[0] > 0), 20'd1);
    check("frames.m1", 20'(frames_w[1] > 0), 20'd1);
    check("frames.m2", 20'(frames_w[2] > 0), 20'd1);
    check("frames.m3", 20'(frames_w[3] > 0), 20'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
